// File: rtl/inst_fifo_if.sv
// Fetch-to-decode instruction queue bundle: dual write slots, dual read lanes.
interface inst_fifo_if;
  logic        flush;
  logic        wr_en0;
  logic        wr_en1;
  logic [31:0] wr_inst0;
  logic [31:0] wr_inst1;
  logic [31:0] wr_pc0;
  logic [31:0] wr_pc1;
  logic        wr_exc0;
  logic        wr_exc1;
  logic        full;
  logic        empty;
  logic        rd_valid0;
  logic        rd_valid1;
  logic [31:0] rd_inst0;
  logic [31:0] rd_inst1;
  logic [31:0] rd_pc0;
  logic [31:0] rd_pc1;
  logic        rd_exc0;
  logic        rd_exc1;
  logic        rd_en0;
  logic        rd_en1;

  // Fetch/decode side: drives pushes, pops and flush.
  modport master (
    output flush, wr_en0, wr_en1, wr_inst0, wr_inst1, wr_pc0, wr_pc1, wr_exc0, wr_exc1,
    output rd_en0, rd_en1,
    input  full, empty, rd_valid0, rd_valid1, rd_inst0, rd_inst1, rd_pc0, rd_pc1,
    input  rd_exc0, rd_exc1
  );

  // Queue side.
  modport slave (
    input  flush, wr_en0, wr_en1, wr_inst0, wr_inst1, wr_pc0, wr_pc1, wr_exc0, wr_exc1,
    input  rd_en0, rd_en1,
    output full, empty, rd_valid0, rd_valid1, rd_inst0, rd_inst1, rd_pc0, rd_pc1,
    output rd_exc0, rd_exc1
  );
endinterface

// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction queue with first-word-fall-through read lanes.
module inst_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  inst_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          exc_q  [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d, wptr_p1;
  logic [AW-1:0] rptr_q, rptr_d, rptr_p1;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    np, nr, nr_req;
  logic          full, valid0, valid1;

  assign wptr_p1 = wptr_q + AW'(1);
  assign rptr_p1 = rptr_q + AW'(1);

  // Flags come from registered count only; full ignores a same-cycle pop.
  assign full   = count_q > CW'(DEPTH - 2);
  assign valid0 = count_q != '0;
  assign valid1 = count_q > CW'(1);

  // Push and pop sizes; a push while full is dropped whole, pops clamp to occupancy.
  always_comb begin
    np = 2'd0;
    if (bus.wr_en0 && !full) np = bus.wr_en1 ? 2'd2 : 2'd1;
    nr_req = 2'd0;
    if (bus.rd_en0) nr_req = bus.rd_en1 ? 2'd2 : 2'd1;
    nr = nr_req;
    // Only reachable with count 0 or 1, so the low bits hold the whole value.
    if (CW'(nr_req) > count_q) nr = count_q[1:0];
  end

  // Pointer and occupancy next state; flush wins over push and pop.
  always_comb begin
    wptr_d  = wptr_q + AW'(np);
    rptr_d  = rptr_q + AW'(nr);
    count_d = count_q + CW'(np) - CW'(nr);
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Pointer/occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are never cleared, invalid lanes are masked on read.
  always_ff @(posedge clk) begin
    if (resetn && !bus.flush && np != 2'd0) begin
      inst_q[wptr_q] <= bus.wr_inst0;
      pc_q[wptr_q]   <= bus.wr_pc0;
      exc_q[wptr_q]  <= bus.wr_exc0;
      if (np == 2'd2) begin
        inst_q[wptr_p1] <= bus.wr_inst1;
        pc_q[wptr_p1]   <= bus.wr_pc1;
        exc_q[wptr_p1]  <= bus.wr_exc1;
      end
    end
  end

  // Read lanes: head to lane 0, head+1 to lane 1, zeroed when not valid.
  always_comb begin
    bus.rd_inst0 = '0;
    bus.rd_pc0   = '0;
    bus.rd_exc0  = 1'b0;
    bus.rd_inst1 = '0;
    bus.rd_pc1   = '0;
    bus.rd_exc1  = 1'b0;
    if (valid0) begin
      bus.rd_inst0 = inst_q[rptr_q];
      bus.rd_pc0   = pc_q[rptr_q];
      bus.rd_exc0  = exc_q[rptr_q];
    end
    if (valid1) begin
      bus.rd_inst1 = inst_q[rptr_p1];
      bus.rd_pc1   = pc_q[rptr_p1];
      bus.rd_exc1  = exc_q[rptr_p1];
    end
  end

  assign bus.full      = full;
  assign bus.empty     = !valid0;
  assign bus.rd_valid0 = valid0;
  assign bus.rd_valid1 = valid1;
endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue model tracks every push/pop/flush/reset.
module tb_inst_fifo;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t sb[$];

  inst_fifo_if bus ();

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs against the model's current contents.
  task automatic check_outputs(input string tag);
    ent_t h0, h1;
    h0 = '0;
    h1 = '0;
    if (sb.size() >= 1) h0 = sb[0];
    if (sb.size() >= 2) h1 = sb[1];
    check_eq({tag, ".empty"},  32'(bus.empty),     32'(sb.size() == 0));
    check_eq({tag, ".full"},   32'(bus.full),      32'((DEPTH - sb.size()) < 2));
    check_eq({tag, ".valid0"}, 32'(bus.rd_valid0), 32'(sb.size() >= 1));
    check_eq({tag, ".valid1"}, 32'(bus.rd_valid1), 32'(sb.size() >= 2));
    check_eq({tag, ".inst0"},  bus.rd_inst0,       h0.inst);
    check_eq({tag, ".pc0"},    bus.rd_pc0,         h0.pc);
    check_eq({tag, ".exc0"},   32'(bus.rd_exc0),   32'(h0.exc));
    check_eq({tag, ".inst1"},  bus.rd_inst1,       h1.inst);
    check_eq({tag, ".pc1"},    bus.rd_pc1,         h1.pc);
    check_eq({tag, ".exc1"},   32'(bus.rd_exc1),   32'(h1.exc));
  endtask

  // One clock of stimulus; checks state before the edge, then updates the model.
  task automatic step(input string tag, input logic fl, input logic w0, input logic w1,
                      input logic r0, input logic r1,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
    ent_t e0, e1, got;
    int   n;
    bit   full_m;
    e0 = '{inst: i0, pc: p0, exc: 1'($urandom)};
    e1 = '{inst: i1, pc: p1, exc: 1'($urandom)};
    bus.flush    = fl;
    bus.wr_en0   = w0;
    bus.wr_en1   = w1;
    bus.wr_inst0 = e0.inst;
    bus.wr_pc0   = e0.pc;
    bus.wr_exc0  = e0.exc;
    bus.wr_inst1 = e1.inst;
    bus.wr_pc1   = e1.pc;
    bus.wr_exc1  = e1.exc;
    bus.rd_en0   = r0;
    bus.rd_en1   = r1;
    #1;
    check_outputs(tag);
    full_m = (DEPTH - sb.size()) < 2;
    if (fl) begin
      sb.delete();
    end else begin
      n = r0 ? (r1 ? 2 : 1) : 0;
      if (n > sb.size()) n = sb.size();
      for (int i = 0; i < n; i++) begin
        got = sb.pop_front();
        check_eq({tag, ".pop_pc"}, (i == 0) ? bus.rd_pc0 : bus.rd_pc1, got.pc);
      end
      if (w0 && !full_m) begin
        sb.push_back(e0);
        if (w1) sb.push_back(e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push1(input string tag, input logic [31:0] pc);
    step(tag, 0, 1, 0, 0, 0, $urandom, pc, 0, 0);
  endtask

  task automatic push2(input string tag, input logic [31:0] pa, input logic [31:0] pb);
    step(tag, 0, 1, 1, 0, 0, $urandom, pa, $urandom, pb);
  endtask

  task automatic pop(input string tag, input logic two);
    step(tag, 0, 0, 0, 1, two, 0, 0, 0, 0);
  endtask

  // Reset asserted for one edge with busy inputs; all entries are lost.
  task automatic do_reset(input string tag);
    resetn       = 1'b0;
    bus.flush    = 1'b0;
    bus.wr_en0   = 1'b1;
    bus.wr_en1   = 1'b1;
    bus.wr_pc0   = 32'hDEAD0000;
    bus.wr_pc1   = 32'hDEAD0004;
    bus.rd_en0   = 1'b1;
    bus.rd_en1   = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sb.delete();
    check_outputs(tag);
  endtask

  initial begin
    bus.wr_inst0 = '0;
    bus.wr_inst1 = '0;
    bus.wr_exc0  = 1'b0;
    bus.wr_exc1  = 1'b0;
    do_reset("reset");
    idle("reset_idle");

    // Directed dual push, then dual pop.
    step("dual_push", 0, 1, 1, 0, 0, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004);
    check_eq("dp.inst0", bus.rd_inst0, 32'h24020001);
    check_eq("dp.inst1", bus.rd_inst1, 32'h24030002);
    pop("dual_pop", 1);
    idle("after_dual_pop");

    // Fill to the full threshold, drop a push while full, then release one entry.
    for (int i = 0; i < DEPTH - 2; i++) push1("fill", 32'h1000 + 32'(i * 4));
    push1("fill_last", 32'h1FFC);
    push2("drop_when_full", 32'hEEEE0000, 32'hEEEE0004);
    pop("pop_one", 0);
    idle("after_release");
    for (int i = 0; i < DEPTH / 2; i++) pop("drain", 1);
    idle("drained");

    // wr_en1 without wr_en0 is ignored.
    step("wr1_only", 0, 0, 1, 0, 0, 0, 0, 32'h12345678, 32'h400);
    idle("wr1_only_idle");

    // Walk both pointers to DEPTH-1, then push across the wrap.
    step("flush_pre_wrap", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step("walk", 0, 1, 0, 1, 0, $urandom, 32'h80 + 32'(i), 0, 0);
    pop("walk_last", 0);
    push2("wrap_push", 32'h100, 32'h104);
    pop("wrap_pop", 1);
    push1("post_wrap", 32'h555);
    pop("post_wrap_pop", 0);

    // Pop clamp with a single entry.
    push1("clamp_push", 32'h200);
    pop("clamp_pop", 1);
    idle("clamp_idle");

    // Flush at count 5 with simultaneous push and pop.
    push2("f_fill", 32'hA0, 32'hA4);
    push2("f_fill", 32'hA8, 32'hAC);
    push1("f_fill", 32'hB0);
    step("flush_busy", 1, 1, 1, 1, 0, $urandom, 32'hC0, $urandom, 32'hC4);
    idle("after_flush");
    push1("push_300", 32'h300);
    idle("see_300");
    check_eq("pc0_300", bus.rd_pc0, 32'h300);

    // Reset mid-operation.
    push2("pre_reset", 32'hD0, 32'hD4);
    do_reset("mid_reset");
    idle("mid_reset_idle");

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    end
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
